// File: rtl/systolic_pe.sv
// Signed multiply-accumulate processing element for a systolic array.
// Operands are forwarded east/south with one register of delay, and a beat-counted dot product is returned over a valid/yumi handshake.
module systolic_pe #(
  parameter int width_p     = 8,
  parameter int acc_width_p = 24,
  parameter int len_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic [len_width_p-1:0] len_i,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  input  logic                   valid_i,
  output logic [width_p-1:0]     a_o,
  output logic [width_p-1:0]     b_o,
  output logic                   valid_o,
  output logic [acc_width_p-1:0] acc_o,
  output logic                   result_v_o,
  input  logic                   result_yumi_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_reg, state_next;
  logic [acc_width_p-1:0]   acc_reg, acc_next;
  logic [len_width_p-1:0]   cnt_reg, cnt_next;
  logic [width_p-1:0]       a_fwd_reg, b_fwd_reg;
  logic                     valid_fwd_reg;

  logic signed [2*width_p-1:0] prod;
  logic [acc_width_p-1:0]      prod_ext;

  assign prod = $signed(a_i) * $signed(b_i);

  // The product must be sign-extended into the accumulator width.
  // A zero-width replication is not legal, so equal widths take a separate branch.
  generate
    if (acc_width_p > 2*width_p) begin : g_sext
      assign prod_ext = {{(acc_width_p-2*width_p){prod[2*width_p-1]}}, prod};
    end else begin : g_nosext
      assign prod_ext = prod[acc_width_p-1:0];
    end
  endgenerate

  // Forwarding path runs in every state and does not depend on the FSM.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_fwd_reg     <= '0;
      b_fwd_reg     <= '0;
      valid_fwd_reg <= 1'b0;
    end else begin
      a_fwd_reg     <= a_i;
      b_fwd_reg     <= b_i;
      valid_fwd_reg <= valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          acc_next = '0;
          cnt_next = len_i;
          state_next = (len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (valid_i) begin
          acc_next = acc_reg + prod_ext;
          cnt_next = cnt_reg - len_width_p'(1);
          if (cnt_reg == len_width_p'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // A start alongside yumi is taken exactly as a start from IDLE, so there is no turnaround bubble.
        if (result_yumi_i) begin
          if (start_i) begin
            acc_next = '0;
            cnt_next = len_i;
            state_next = (len_i != '0) ? RUN : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  assign a_o        = a_fwd_reg;
  assign b_o        = b_fwd_reg;
  assign valid_o    = valid_fwd_reg;
  assign acc_o      = acc_reg;
  assign result_v_o = (state_reg == DONE);

endmodule
